// File: rtl/ff_bank_unloader.sv
// Flop-bank read-out: snapshots parallel Q outputs on CAP and
// streams them out one bit per accepted valid/ready beat.
module ff_bank_unloader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             CAP,
  input  logic [WIDTH-1:0] PD,
  output logic             SO,
  output logic             SO_VLD,
  input  logic             SO_RDY,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_so;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;
  logic             r_ovr;

  logic [WIDTH-1:0] w_shifted;
  logic             w_pd_bit;
  logic             w_sh_bit;

  // SO is registered, so the next bit is selected from the
  // post-shift value rather than from the current register.
  always_comb begin
    w_shifted = '0;
    if (MSB_FIRST)
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    else
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    w_pd_bit = MSB_FIRST ? PD[WIDTH-1] : PD[0];
    w_sh_bit = MSB_FIRST ? w_shifted[WIDTH-1]
                         : w_shifted[0];
  end

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (CAP) begin
            r_shreg <= PD;
            r_cnt   <= CNT_INIT;
            r_ovr   <= 1'b0;
            r_so    <= w_pd_bit;
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (CAP)
            r_ovr <= 1'b1;
          if (SO_RDY) begin
            r_shreg <= w_shifted;
            if (r_cnt == '0) begin
              r_so    <= 1'b0;
              r_vld   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= LAST;
            end else begin
              r_so  <= w_sh_bit;
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        LAST: begin
          if (CAP)
            r_ovr <= 1'b1;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_vld   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign SO     = r_so;
  assign SO_VLD = r_vld;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign OVR    = r_ovr;

endmodule

// File: tb/tb_ff_bank_unloader.sv
// Directed bench for ff_bank_unloader: an LSB-first and an
// MSB-first instance share all inputs.
module tb_ff_bank_unloader;

  logic       CP = 1'b0;
  logic       CD;
  logic       CAP;
  logic [7:0] PD;
  logic       SO_RDY;
  logic       SO0, VLD0, BUSY0, DONE0, OVR0;
  logic       SO1, VLD1, BUSY1, DONE1, OVR1;

  int tests = 0;
  int fails = 0;

  always #5 CP = ~CP;

  ff_bank_unloader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .CP(CP), .CD(CD), .CAP(CAP), .PD(PD),
    .SO(SO0), .SO_VLD(VLD0), .SO_RDY(SO_RDY),
    .BUSY(BUSY0), .DONE(DONE0), .OVR(OVR0)
  );

  ff_bank_unloader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CP(CP), .CD(CD), .CAP(CAP), .PD(PD),
    .SO(SO1), .SO_VLD(VLD1), .SO_RDY(SO_RDY),
    .BUSY(BUSY1), .DONE(DONE1), .OVR(OVR1)
  );

  task automatic tick;
    @(posedge CP);
    #1;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  task automatic capture(input logic [7:0] pd);
    CAP = 1'b1;
    PD  = pd;
    tick();
    CAP = 1'b0;
    PD  = ~pd;
  endtask

  // mode 0: SO_RDY always 1; mode 1: SO_RDY pattern 1,0,0,1
  task automatic run_stream(
    input  int         mode,
    input  int         cap_at,
    input  int         cycles,
    output logic [7:0] g0,
    output logic [7:0] g1,
    output int         beats,
    output int         dones,
    output int         done_at,
    output int         bad
  );
    logic rdy, stalled, hold;
    g0 = '0; g1 = '0;
    beats = 0; dones = 0; done_at = -1; bad = 0;
    stalled = 1'b0; hold = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      rdy = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (stalled && (SO0 !== hold || VLD0 !== 1'b1)) bad++;
      if (VLD0 !== VLD1) bad++;
      if (DONE0 === 1'b1) begin
        dones++;
        done_at = c;
      end
      if (VLD0 === 1'b1 && rdy && beats < 8) begin
        g0[beats] = SO0;
        g1[beats] = SO1;
        beats++;
      end
      stalled = (VLD0 === 1'b1) && !rdy;
      hold    = SO0;
      SO_RDY  = rdy;
      CAP     = (c == cap_at);
      tick();
    end
    CAP = 1'b0;
  endtask

  task automatic test_reset;
    CD = 1'b1; CAP = 1'b0; PD = 8'h00; SO_RDY = 1'b0;
    #3;
    tests++;
    if ({SO0, VLD0, BUSY0, DONE0, OVR0, SO1, VLD1, BUSY1, DONE1, OVR1}
        !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=0",
        {SO0, VLD0, BUSY0, DONE0, OVR0, SO1, VLD1, BUSY1, DONE1, OVR1});
    end
    tick();
    CD = 1'b0;
    tick();
    tests++;
    if (BUSY0 !== 1'b0 || VLD0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b vld=%b want 0,0", BUSY0, VLD0);
    end
  endtask

  task automatic test_stream_a5;
    logic [7:0] g0, g1;
    int beats, dones, done_at, bad;
    SO_RDY = 1'b1;
    capture(8'hA5);
    tests++;
    if (VLD0 !== 1'b1 || BUSY0 !== 1'b1) begin
      fails++;
      $display("FAIL a5_latency vld=%b busy=%b want 1,1", VLD0, BUSY0);
    end
    run_stream(0, -1, 12, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (g0 !== 8'hA5) begin
      fails++;
      $display("FAIL a5_lsb_stream got=%h want=a5", g0);
    end
    tests++;
    if (g1 !== 8'hA5) begin
      fails++;
      $display("FAIL a5_msb_stream got=%h want=a5", g1);
    end
    tests++;
    if (dones != 1 || done_at != 8) begin
      fails++;
      $display("FAIL a5_done count=%0d at=%0d want 1 at 8", dones, done_at);
    end
    tests++;
    if (BUSY0 !== 1'b0 || bad != 0) begin
      fails++;
      $display("FAIL a5_end busy=%b bad=%0d want 0,0", BUSY0, bad);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] g0, g1;
    int beats, dones, done_at, bad;
    SO_RDY = 1'b1;
    capture(8'h01);
    run_stream(0, -1, 12, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (g1 !== rev8(8'h01)) begin
      fails++;
      $display("FAIL msb_01_stream got=%h want=%h", g1, rev8(8'h01));
    end
    tests++;
    if (g0 !== 8'h01 || beats != 8) begin
      fails++;
      $display("FAIL lsb_01_stream got=%h beats=%0d want 01,8", g0, beats);
    end
  endtask

  task automatic test_stall;
    logic [7:0] g0, g1;
    int beats, dones, done_at, bad;
    SO_RDY = 1'b1;
    capture(8'h3C);
    run_stream(1, -1, 22, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (g0 !== 8'h3C || g1 !== rev8(8'h3C)) begin
      fails++;
      $display("FAIL stall_stream got=%h/%h want 3c/3c", g0, g1);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold violations=%0d want 0", bad);
    end
    tests++;
    if (dones != 1 || done_at != 16) begin
      fails++;
      $display("FAIL stall_done count=%0d at=%0d want 1 at 16", dones, done_at);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] g0, g1;
    int beats, dones, done_at, bad;
    SO_RDY = 1'b1;
    capture(8'hA5);
    run_stream(0, 2, 12, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (g0 !== 8'hA5 || dones != 1 || done_at != 8) begin
      fails++;
      $display("FAIL ovr_stream got=%h done=%0d at=%0d want a5,1,8",
        g0, dones, done_at);
    end
    tests++;
    if (OVR0 !== 1'b1 || OVR1 !== 1'b1) begin
      fails++;
      $display("FAIL ovr_sticky got=%b%b want 11", OVR0, OVR1);
    end
    capture(8'h5A);
    tests++;
    if (OVR0 !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear got=%b want 0", OVR0);
    end
    run_stream(0, 8, 9, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (OVR0 !== 1'b1 || BUSY0 !== 1'b0 || g0 !== 8'h5A) begin
      fails++;
      $display("FAIL ovr_last ovr=%b busy=%b got=%h want 1,0,5a",
        OVR0, BUSY0, g0);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] g0, g1;
    int beats, dones, done_at, bad;
    SO_RDY = 1'b1;
    capture(8'hA5);
    repeat (4) tick();
    #2;
    CD = 1'b1;
    #1;
    tests++;
    if ({SO0, VLD0, BUSY0, DONE0, OVR0} !== 5'b0 || CP !== 1'b1) begin
      fails++;
      $display("FAIL async_reset got=%b want 00000",
        {SO0, VLD0, BUSY0, DONE0, OVR0});
    end
    tick();
    CD = 1'b0;
    run_stream(0, -1, 10, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (BUSY0 !== 1'b0 || dones != 0 || beats != 0) begin
      fails++;
      $display("FAIL post_reset busy=%b dones=%0d beats=%0d want 0,0,0",
        BUSY0, dones, beats);
    end
    capture(8'hFF);
    run_stream(0, -1, 12, g0, g1, beats, dones, done_at, bad);
    tests++;
    if (g0 !== 8'hFF || beats != 8 || dones != 1) begin
      fails++;
      $display("FAIL post_reset_ff got=%h beats=%0d dones=%0d want ff,8,1",
        g0, beats, dones);
    end
  endtask

  task automatic test_back_to_back;
    int bad_pat, dones;
    logic ev, ed;
    bad_pat = 0;
    dones   = 0;
    SO_RDY  = 1'b1;
    CAP     = 1'b1;
    PD      = 8'h96;
    tick();
    for (int c = 0; c < 30; c++) begin
      ev = (c % 10) < 8;
      ed = (c % 10) == 8;
      if (VLD0 !== ev || DONE0 !== ed) bad_pat++;
      if (DONE0 === 1'b1) dones++;
      if (c == 9 || c == 19) begin
        tests++;
        if (OVR0 !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ovr_set c=%0d got=%b want 1", c, OVR0);
        end
      end
      if (c == 10) begin
        tests++;
        if (OVR0 !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ovr_clear got=%b want 0", OVR0);
        end
      end
      tick();
    end
    CAP = 1'b0;
    tests++;
    if (bad_pat != 0 || dones != 3) begin
      fails++;
      $display("FAIL b2b_pattern errs=%0d dones=%0d want 0,3",
        bad_pat, dones);
    end
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_stream_a5();
    test_msb_first();
    test_stall();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
